// File: rtl/ldpc_cn_min_scanner_pkg.sv
// Shared types and helpers for the min-sum check-node scanner.
//   cn_scan_state_t : scanner FSM states (COLLECT accepts beats, HOLD presents the result)
//   MAG_MAX(width)  : all-ones magnitude of the given width, returned in 32 bits
package ldpc_cn_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } cn_scan_state_t;

  function automatic logic [31:0] MAG_MAX(input int unsigned width);
    if (width >= 32) begin
      return '1;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/ldpc_cn_min_scanner_if.sv
// Handshake bundle of the check-node scanner.
//   in_*  : variable-to-check beat stream (valid/ready, magnitude, sign)
//   out_* : one result beat per check node (valid/ready, min1, min2, min1 index, sign parity)
// Modports: slave = the scanner, master = the source/sink surrounding it.
interface ldpc_cn_min_scanner_if #(
  parameter int unsigned MAG_W = 5,
  parameter int unsigned IDX_W = 3
);

  logic             in_valid;
  logic             in_ready;
  logic [MAG_W-1:0] in_mag;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W-1:0] out_min1;
  logic [MAG_W-1:0] out_min2;
  logic [IDX_W-1:0] out_min1_idx;
  logic             out_parity;

  modport slave (
    input  in_valid, in_mag, in_sign, out_ready,
    output in_ready, out_valid, out_min1, out_min2, out_min1_idx, out_parity
  );

  modport master (
    output in_valid, in_mag, in_sign, out_ready,
    input  in_ready, out_valid, out_min1, out_min2, out_min1_idx, out_parity
  );

endinterface

// File: rtl/ldpc_cn_min_scanner_counter.sv
// Beat counter for the check-node scanner.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : advance by one (one accepted beat)
//   cnt          : current beat index, wraps from DEGREE-1 to 0
//   first, last  : cnt == 0, cnt == DEGREE-1
module cn_scan_counter #(
  parameter int unsigned DEGREE = 6,
  parameter int unsigned IDX_W  = $clog2(DEGREE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [IDX_W-1:0] cnt,
  output logic             first,
  output logic             last
);

  logic [IDX_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + IDX_W'(1);
    end
  end

  assign cnt   = cnt_q;
  assign first = (cnt_q == '0);
  assign last  = (cnt_q == IDX_W'(DEGREE - 1));

endmodule

// File: rtl/ldpc_cn_min_scanner.sv
// Serial min-sum check-node scanner.
// Accepts DEGREE magnitude/sign beats, tracks min1, min2 (min over all indices but min1's),
// the index of min1 and the sign parity, then holds one result beat until it is taken.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : ldpc_cn_min_scanner_if.slave (input beat stream and result beat)
// Build option: CN_MIN_OFFSET_EN subtracts OFFSET (saturating at 0) from out_min1/out_min2;
// the scan itself always compares raw magnitudes.
module ldpc_cn_min_scanner
  import ldpc_cn_pkg::*;
#(
  parameter int unsigned DEGREE = 6,
  parameter int unsigned MAG_W  = 5,
  parameter int unsigned IDX_W  = $clog2(DEGREE),
  parameter int unsigned OFFSET = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  ldpc_cn_min_scanner_if.slave bus
);

  localparam logic [MAG_W-1:0] MagAllOnes = MAG_W'(MAG_MAX(MAG_W));

  cn_scan_state_t   state_q, state_d;
  logic [MAG_W-1:0] min1_q, min2_q;
  logic [IDX_W-1:0] idx_q;
  logic             parity_q;
  logic             accept;
  logic [IDX_W-1:0] cnt;
  logic             first, last;

  assign accept = bus.in_valid && (state_q == COLLECT);

  cn_scan_counter #(
    .DEGREE (DEGREE),
    .IDX_W  (IDX_W)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (accept),
    .cnt     (cnt),
    .first   (first),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (accept && last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Strict '<' keeps the first occurrence as min1; an equal later value lands in min2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min1_q   <= MagAllOnes;
      min2_q   <= MagAllOnes;
      idx_q    <= '0;
      parity_q <= 1'b0;
    end else if (accept) begin
      if (first) begin
        min1_q   <= bus.in_mag;
        min2_q   <= MagAllOnes;
        idx_q    <= '0;
        parity_q <= bus.in_sign;
      end else begin
        if (bus.in_mag < min1_q) begin
          min2_q <= min1_q;
          min1_q <= bus.in_mag;
          idx_q  <= cnt;
        end else if (bus.in_mag < min2_q) begin
          min2_q <= bus.in_mag;
        end
        parity_q <= parity_q ^ bus.in_sign;
      end
    end
  end

  assign bus.out_min1_idx = idx_q;
  assign bus.out_parity   = parity_q;

`ifdef CN_MIN_OFFSET_EN
  localparam logic [MAG_W-1:0] OffsetW = MAG_W'(OFFSET);

  assign bus.out_min1 = (min1_q > OffsetW) ? (min1_q - OffsetW) : '0;
  assign bus.out_min2 = (min2_q > OffsetW) ? (min2_q - OffsetW) : '0;
`else
  logic unused_offset;

  assign unused_offset = ^MAG_W'(OFFSET);
  assign bus.out_min1  = min1_q;
  assign bus.out_min2  = min2_q;
`endif

endmodule

// File: doc/ldpc_cn_min_scanner.md
# ldpc_cn_min_scanner

Serial min-sum check-node scanner for the belief-propagation decoder. It accepts the DEGREE variable-to-check magnitudes and signs of one check node, one beat per cycle. It tracks the minimum, the second minimum (the minimum over every index except the minimum's position), the index of the minimum and the sign parity, then presents one result beat with valid/ready backpressure. It is the parametrised successor of the 2-bit skip-index counter, generalised to any node degree and magnitude width, with streaming handshakes and a stateful scan.

## Interface
- DEGREE, 6: check-node degree, ≥2
- MAG_W, 5: magnitude width in bits
- IDX_W, $clog2(DEGREE): index width
- OFFSET, 1: offset min-sum constant; used only when CN_MIN_OFFSET_EN is defined
- clk  in  1  rising-edge clock; the block has one clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat; high in COLLECT only
- in_mag  in  MAG_W  unsigned message magnitude
- in_sign  in  1  message sign (1 = negative)
- out_valid  out  1  result valid; high in HOLD only
- out_ready  in  1  downstream accepts the result
- out_min1  out  MAG_W  minimum magnitude
- out_min2  out  MAG_W  second minimum magnitude
- out_min1_idx  out  IDX_W  beat index of the minimum
- out_parity  out  1  XOR of all DEGREE signs

## Operation
- States: COLLECT and HOLD. Reset state is COLLECT.
- Reset values:
  - cnt = 0, min1 = all-ones, min2 = all-ones, idx = 0, parity = 0
  - out_valid = 0; in_ready follows state, so it is 1 in COLLECT
- An input beat is accepted when in_valid && in_ready.
- First beat (cnt == 0): min1 = in_mag, min2 = all-ones, idx = 0, parity = in_sign.
- Each later beat:
  - If in_mag < min1: min2 = min1, min1 = in_mag, idx = cnt.
  - Else if in_mag < min2: min2 = in_mag.
  - Always: parity ^= in_sign.
- Ties: the first occurrence keeps idx. An equal later value sets min2 = min1.
- cnt increments on each accepted beat. A beat accepted with cnt == DEGREE-1 wraps cnt to 0 and moves the state to HOLD.
- HOLD: in_ready = 0, out_valid = 1. Outputs are stable until out_valid && out_ready, which returns the state to COLLECT.
- Outputs are driven from the working registers and are meaningful only while out_valid = 1.
- Beats offered in HOLD are not consumed. The source must hold them.
- Reset asserted mid-scan discards the partial scan. No result is produced for it.
- Arithmetic is unsigned compare only; there is no overflow path.

## Timing
- out_valid rises the cycle after the last beat is accepted.
- The result is held at least 1 cycle.
- in_ready rises the cycle after the output handshake.
- Minimum cost is DEGREE+1 cycles per check node (HOLD always lasts at least one cycle).
- in_ready and out_valid are decoded from the state register. There is no combinational path from in_valid or out_ready.

## Configuration
- CN_MIN_OFFSET_EN defined: out_min1 and out_min2 each output max(value − OFFSET, 0), computed combinationally from the registers. Internal comparisons still use raw values.
- CN_MIN_OFFSET_EN undefined: outputs are raw and OFFSET is ignored.

## Structure
- Package ldpc_cn_pkg holds:
  - typedef cn_scan_state_t {COLLECT, HOLD}
  - a MAG_MAX(width) all-ones constant function
- Sub-module cn_scan_counter holds cnt:
  - IDX_W-bit counter with enable and wrap at DEGREE-1
  - outputs cnt, first (cnt == 0) and last (cnt == DEGREE-1)

## Test plan
All scenarios use DEGREE=6, MAG_W=5 and offset disabled unless noted.
1. Mags 9,3,7,3,12,5 with signs 1,0,1,1,0,0 → min1=3, idx=1, min2=3, parity=1; out_valid one cycle after beat 6.
2. Mags 20,15,10,8,4,2 → min1=2, idx=5, min2=4.
3. Mags 1,6,6,6,6,31 → min1=1, idx=0, min2=6.
4. Hold out_ready low for 4 cycles after the result, with a 7th beat offered → out_valid held, outputs stable, in_ready=0, beat not consumed until the cycle after the handshake.
5. Assert reset_n low after 3 beats, then send all mags 5 with signs 1,1,0,0,0,0 → min1=5, idx=0, min2=5, parity=0.
6. CN_MIN_OFFSET_EN with OFFSET=1 → scenario 1 gives 2/2; mags 0,4,9,9,9,9 give min1=0 (saturated) and min2=3.
